// File: rtl/pwm_input_conditioner_if.sv
// pwm_input_conditioner_if: PWM pin in, conditioned level/strobes/flags/glitch count out
// master: the side that owns the raw pin and consumes the conditioned outputs
// slave:  the conditioner itself
interface pwm_input_conditioner_if #(
    parameter int GLITCH_W = 16
);
    logic                signal_raw;
    logic                signal_clean;
    logic                rise_pulse;
    logic                fall_pulse;
    logic                stuck_high;
    logic                stuck_low;
    logic [GLITCH_W-1:0] glitch_cnt;
    modport master (
        output signal_raw,
        input  signal_clean, rise_pulse, fall_pulse, stuck_high, stuck_low, glitch_cnt
    );
    modport slave (
        input  signal_raw,
        output signal_clean, rise_pulse, fall_pulse, stuck_high, stuck_low, glitch_cnt
    );
endinterface

// File: rtl/pwm_input_conditioner.sv
// pwm_input_conditioner: synchronise and deglitch a PWM pin, strobe clean edges, flag stuck levels
// Ports: clk; rst_n (synchronous, active-low); bus (slave) carries signal_raw in and
//   signal_clean, rise_pulse, fall_pulse, stuck_high, stuck_low, glitch_cnt out.
// Define COND_GLITCH_CNT_EN to build the saturating glitch counter; otherwise glitch_cnt reads 0.
module pwm_input_conditioner #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int GLITCH_W       = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    pwm_input_conditioner_if.slave   bus
);
    localparam int FW = $clog2(FILTER_LEN) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);
    typedef enum logic [1:0] {S_LOW, S_RISE_QUAL, S_HIGH, S_FALL_QUAL} state_t;
    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state, w_state_nxt;
    logic [FW-1:0]          r_flt_cnt, w_flt_nxt;
    logic [TW-1:0]          r_tmo;
    logic                   r_rise, r_fall, w_rise_nxt, w_fall_nxt, w_sync_q, w_clean;
    assign w_sync_q = r_sync[SYNC_STAGES-1];
    // The level only changes on qualification, so it is implied by the state.
    assign w_clean  = r_state == S_HIGH || r_state == S_FALL_QUAL;
    always_comb begin
        w_state_nxt = r_state;
        w_flt_nxt   = r_flt_cnt;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        case (r_state)
            S_LOW: if (w_sync_q) begin
                w_state_nxt = S_RISE_QUAL;
                w_flt_nxt   = FW'(1);
            end
            S_RISE_QUAL: if (!w_sync_q) w_state_nxt = S_LOW;
                else if (r_flt_cnt == FLT_LAST) begin
                    w_state_nxt = S_HIGH;
                    w_rise_nxt  = 1'b1;
                end else w_flt_nxt = r_flt_cnt + FW'(1);
            S_HIGH: if (!w_sync_q) begin
                w_state_nxt = S_FALL_QUAL;
                w_flt_nxt   = FW'(1);
            end
            S_FALL_QUAL: if (w_sync_q) w_state_nxt = S_HIGH;
                else if (r_flt_cnt == FLT_LAST) begin
                    w_state_nxt = S_LOW;
                    w_fall_nxt  = 1'b1;
                end else w_flt_nxt = r_flt_cnt + FW'(1);
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync    <= '0;
            r_state   <= S_LOW;
            r_flt_cnt <= '0;
            r_tmo     <= '0;
            r_rise    <= 1'b0;
            r_fall    <= 1'b0;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], bus.signal_raw};
            r_state   <= w_state_nxt;
            r_flt_cnt <= w_flt_nxt;
            r_rise    <= w_rise_nxt;
            r_fall    <= w_fall_nxt;
            // A clean edge beats saturation: flags drop the same cycle the pulse shows.
            r_tmo     <= (w_rise_nxt || w_fall_nxt) ? '0 : (r_tmo == TMO_MAX ? r_tmo : r_tmo + TW'(1));
        end
    end
    assign bus.signal_clean = w_clean;
    assign bus.rise_pulse   = r_rise;
    assign bus.fall_pulse   = r_fall;
    assign bus.stuck_high   = r_tmo == TMO_MAX && w_clean;
    assign bus.stuck_low    = r_tmo == TMO_MAX && !w_clean;
`ifdef COND_GLITCH_CNT_EN
    logic [GLITCH_W-1:0] r_glitch;
    logic                w_glitch;
    // A candidate is rejected when the synced level reverts before qualification completes.
    assign w_glitch = (r_state == S_RISE_QUAL && !w_sync_q) || (r_state == S_FALL_QUAL && w_sync_q);
    always_ff @(posedge clk) begin
        if (!rst_n) r_glitch <= '0;
        else if (w_glitch && r_glitch != '1) r_glitch <= r_glitch + GLITCH_W'(1);
    end
    assign bus.glitch_cnt = r_glitch;
`else
    assign bus.glitch_cnt = GLITCH_W'(0);
`endif
endmodule

// File: tb/tb_pwm_input_conditioner.sv
// tb_pwm_input_conditioner: random and directed stimulus against a run-length reference model
module tb_pwm_input_conditioner;
    localparam int SYNC = 2;
    localparam int FLT  = 4;
    localparam int TMO  = 100;
`ifdef COND_GLITCH_CNT_EN
    localparam bit GEN = 1'b1;
`else
    localparam bit GEN = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic raw = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;
    always #5 clk = ~clk;
    pwm_input_conditioner_if #(.GLITCH_W(16)) bus ();
    pwm_input_conditioner_if #(.GLITCH_W(4))  bus4 ();
    assign bus.signal_raw  = raw;
    assign bus4.signal_raw = raw;
    pwm_input_conditioner #(.SYNC_STAGES(SYNC), .FILTER_LEN(FLT), .TIMEOUT_CYCLES(TMO), .GLITCH_W(16))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    pwm_input_conditioner #(.SYNC_STAGES(SYNC), .FILTER_LEN(FLT), .TIMEOUT_CYCLES(TMO), .GLITCH_W(4))
        dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    bit m_l, m_rise, m_fall, m_live, m_s;
    int m_run, m_tmo, m_g16, m_g4;
    bit q[$];
    // Level flips once FLT consecutive synced samples disagree with it; a broken run is a glitch.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_l = 0; m_rise = 0; m_fall = 0; m_run = 0; m_tmo = 0; m_g16 = 0; m_g4 = 0;
            q.delete();
            repeat (SYNC) q.push_back(1'b0);
        end else begin
            m_s = q.pop_front();
            q.push_back(raw);
            m_rise = 0;
            m_fall = 0;
            if (m_s != m_l) begin
                m_run++;
                if (m_run == FLT) begin
                    m_l = m_s; m_run = 0; m_rise = m_s; m_fall = !m_s;
                end
            end else begin
                if (m_run > 0) begin
                    m_g16 = m_g16 == 65535 ? m_g16 : m_g16 + 1;
                    m_g4  = m_g4 == 15 ? m_g4 : m_g4 + 1;
                end
                m_run = 0;
            end
            m_tmo = (m_rise || m_fall) ? 0 : (m_tmo + 1 > TMO ? TMO : m_tmo + 1);
        end
        m_live = 1;
    end
    function automatic logic [24:0] expv();
        logic [15:0] g16;
        logic [3:0]  g4;
        g16 = GEN ? m_g16[15:0] : 16'h0;
        g4  = GEN ? m_g4[3:0] : 4'h0;
        return {m_l, m_rise, m_fall, m_tmo == TMO && m_l, m_tmo == TMO && !m_l, g16, g4};
    endfunction
    function automatic logic [24:0] act();
        return {bus.signal_clean, bus.rise_pulse, bus.fall_pulse, bus.stuck_high, bus.stuck_low,
                bus.glitch_cnt, bus4.glitch_cnt};
    endfunction
    task automatic check(input string name, input logic [63:0] a, input logic [63:0] e);
        n_chk++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, a, e);
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    always @(negedge clk) if (m_live) check("model", 64'(act()), 64'(expv()));
    initial begin
        for (int i = 0; i < 5; i++) begin
            step();
            raw = ~raw;
            check("reset_outputs", 64'(act()), 0);
        end
        raw = 1'b0;
        rst_n = 1'b1;
        repeat (99) step();
        check("stuck_low_99", 64'(bus.stuck_low), 0);
        step();
        check("stuck_low_100", 64'(bus.stuck_low), 1);
        repeat (10) step();
        check("stuck_low_hold", 64'(bus.stuck_low), 1);
        raw = 1'b1;
        repeat (5) step();
        check("rise_lat5", 64'(bus.signal_clean), 0);
        step();
        check("rise_lat6", 64'(bus.signal_clean), 1);
        check("rise_pulse", 64'(bus.rise_pulse), 1);
        check("stuck_low_clear", 64'(bus.stuck_low), 0);
        check("model_rise_level", 64'(m_l), 1);
        step();
        check("rise_pulse_1cyc", 64'(bus.rise_pulse), 0);
        repeat (98) step();
        check("stuck_high_99", 64'(bus.stuck_high), 0);
        step();
        check("stuck_high_100", 64'(bus.stuck_high), 1);
        check("model_tmo_sat", 64'(m_tmo), 100);
        raw = 1'b0;
        repeat (5) step();
        check("fall_lat5", 64'(bus.signal_clean), 1);
        step();
        check("fall_lat6", 64'(bus.signal_clean), 0);
        check("fall_pulse", 64'(bus.fall_pulse), 1);
        check("stuck_high_clear", 64'(bus.stuck_high), 0);
        step();
        check("fall_pulse_1cyc", 64'(bus.fall_pulse), 0);
        raw = 1'b1;
        repeat (3) step();
        raw = 1'b0;
        repeat (10) step();
        check("glitch_low_level", 64'(bus.signal_clean), 0);
        check("glitch_low_cnt", 64'(bus.glitch_cnt), GEN ? 1 : 0);
        raw = 1'b1;
        repeat (10) step();
        check("go_high", 64'(bus.signal_clean), 1);
        raw = 1'b0;
        repeat (3) step();
        raw = 1'b1;
        repeat (10) step();
        check("glitch_high_level", 64'(bus.signal_clean), 1);
        check("glitch_high_cnt", 64'(bus.glitch_cnt), GEN ? 2 : 0);
        repeat (20) begin
            raw = 1'b0;
            repeat (2) step();
            raw = 1'b1;
            repeat (2) step();
        end
        repeat (10) step();
        check("glitch4_sat", 64'(bus4.glitch_cnt), GEN ? 15 : 0);
        check("glitch16_22", 64'(bus.glitch_cnt), GEN ? 22 : 0);
        repeat (5) begin
            raw = 1'b0;
            repeat (2) step();
            raw = 1'b1;
            repeat (2) step();
        end
        repeat (10) step();
        check("glitch4_no_wrap", 64'(bus4.glitch_cnt), GEN ? 15 : 0);
        check("glitch_level_kept", 64'(bus.signal_clean), 1);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) < 3) begin
                rst_n = 1'b0;
                repeat ($urandom_range(1, 3)) step();
                rst_n = 1'b1;
            end
            raw = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 9) == 0 ? $urandom_range(90, 130) : $urandom_range(1, 7)) step();
        end
        repeat (5) step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
